// File: rtl/bserialsub.sv
// Bit-serial N-bit subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first.
// Latency: done pulses WIDTH cycles after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
module bserialsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             d_bit,
  output logic             d_valid
);

  // Counter must hold 0..WIDTH-1; keep at least one bit for tiny widths.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_d_bit;
  logic             r_d_valid;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs plus the running borrow.
  assign w_x        = r_sa[0];
  assign w_y        = r_sb[0];
  assign w_d        = w_x ^ w_y ^ r_br;
  assign w_br_next  = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_last     = (r_cnt == LAST_CNT);
  // Difference bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

  // Control FSM and datapath; the last shift writes diff/bout directly so done,
  // diff and bout all become visible in the same registered cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sa      <= '0;
      r_sb      <= '0;
      r_res     <= '0;
      r_br      <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_d_bit   <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done    <= 1'b0;
          r_d_valid <= 1'b0;
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sa      <= r_sa >> 1;
          r_sb      <= r_sb >> 1;
          r_res     <= w_res_next;
          r_br      <= w_br_next;
          r_d_bit   <= w_d;
          r_d_valid <= 1'b1;
          r_cnt     <= r_cnt + CW'(1);
          if (w_last) begin
            r_done  <= 1'b1;
            r_diff  <= w_res_next;
            r_bout  <= w_br_next;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Single-cycle done pulse; a start seen here is dropped.
          r_done    <= 1'b0;
          r_d_valid <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign diff    = r_diff;
  assign bout    = r_bout;
  assign d_bit   = r_d_bit;
  assign d_valid = r_d_valid;

endmodule

// File: doc/bserialsub.md
# bserialsub

Bit-serial N-bit subtractor that computes `a - b - bin` one bit per clock, LSB first, using a registered full-subtractor cell and a borrow flip-flop. It is the sequential, inverse-operation counterpart to the team's single-bit full-adder cell. It sits in the same datapath library as a low-area arithmetic unit for callers that trade latency for gate count. It presents a start/busy/done handshake, a parallel result, and a per-bit serial result stream.

## Interface
- `WIDTH`, 8, operand and result width in bits; legal range 2..32.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled on the accepting edge only.
- `b`  input  WIDTH  subtrahend; sampled on the accepting edge only.
- `bin`  input  1  borrow-in; sampled on the accepting edge only.
- `busy`  output  1  high while in SHIFT or DONE.
- `done`  output  1  one-cycle pulse; `diff` and `bout` are final.
- `diff`  output  WIDTH  parallel difference; held until the next accepted start.
- `bout`  output  1  final borrow-out, i.e. unsigned `a < b + bin`; held like `diff`.
- `d_bit`  output  1  serial difference bit, LSB first.
- `d_valid`  output  1  qualifies `d_bit`.

## Operation
- Registers:
  - operand shift registers `sa` and `sb` (WIDTH each)
  - result shift register (WIDTH)
  - borrow flop `br`
  - bit counter (`clog2(WIDTH)` bits)
  - state register
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On `start=1`, capture `sa<=a`, `sb<=b`, `br<=bin`, counter<=0, then go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, every cycle:
  - Compute the cell from `x=sa[0]`, `y=sb[0]`:
    - `d = x ^ y ^ br`
    - `br_next = (~x & y) | (~(x ^ y) & br)`
  - Shift `sa` and `sb` right by one.
  - Shift `d` into the result MSB, shifting the result right by one.
  - Update `br<=br_next`, `d_bit<=d`, `d_valid<=1`, counter+1.
  - When the counter equals `WIDTH-1`, go to DONE.
- DONE:
  - Assert `done=1` and `d_valid=0`.
  - Copy the result register to `diff` and `br` to `bout`.
  - Return to IDLE on the next edge.
- Arithmetic:
  - The result is the modulo-2^WIDTH difference.
  - `bout` is the borrow out of bit WIDTH-1.
  - No signed interpretation is made.
- `start` in SHIFT or DONE is ignored. No queueing, no error flag.
- Changes on `a`, `b` or `bin` after the accepting edge have no effect on the operation in flight.
- `diff` and `bout` update only in DONE, so they stay stable throughout a following operation until that operation's DONE.

## Timing
- Reset (`rst_n=0`, asynchronous assert): state=IDLE and every output is 0: `busy`, `done`, `diff`, `bout`, `d_bit`, `d_valid`. Internal registers are also 0.
- Deassertion is synchronous to `clk`, supplied externally.
- Let E0 be the edge that accepts `start`.
- `busy` is 1 from after E0 through the DONE cycle. It returns to 0 after edge E(WIDTH+1).
- `d_valid` is 1 for exactly WIDTH cycles, after edges E1..EWIDTH. After edge Ei, `d_bit` equals difference bit i-1.
- `done` is 1 for exactly one cycle, after edge EWIDTH (latency WIDTH cycles from acceptance). `diff`/`bout` take final values in that same cycle, all registered.
- The earliest next accepting edge is E(WIDTH+2), because `start` is sampled in IDLE. Throughput is one operation per WIDTH+2 cycles.
- Reset mid-operation: the operation is aborted immediately and the partial result is discarded. After reset releases, the block is in IDLE.
- `start` held high continuously: back-to-back operations every WIDTH+2 cycles, each using the `a`/`b`/`bin` present at its own accepting edge.

## Test plan
- WIDTH=8; `a=0x05`, `b=0x03`, `bin=0`, one-cycle start → `done` 8 cycles after acceptance; `diff=0x02`, `bout=0`; `d_bit` stream 0,1,0,0,0,0,0,0 with `d_valid` high for 8 cycles.
- `a=0x00`, `b=0x01`, `bin=0` → `diff=0xFF`, `bout=1`. Then `a=0x10`, `b=0x10`, `bin=1` → `diff=0xFF`, `bout=1`.
- `a=0xA5`, `b=0x5A`, `bin=1` → `diff=0x4A`, `bout=0`. Also the exhaustive/random sweep of `a`, `b`, `bin` against a reference model computing `{bout,diff} = a - b - bin` (WIDTH+1 bits).
- Pulse `start` with new operands 3 cycles into a busy operation → ignored. The first result is unchanged, no second `done`, `busy` falls at E9.
- Assert `rst_n=0` mid-SHIFT (after E4) → all outputs 0 immediately, asynchronously. After release, a fresh `0x05-0x03` run gives `0x02` with correct latency.
- `start` tied high with operands changing every cycle → `done` pulses exactly every 10 cycles. Each result matches the operands present at its accepting edge.
